// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result packs {remainder, quotient}; ready_o is a pure state decode.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    IDLE,
    DIVZERO,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        sgn1_q, sgn1_d;
  logic        sgn2_q, sgn2_d;
  logic        sdiv_q, sdiv_d;
  logic [63:0] res_q, res_d;

  logic [31:0] mag1, mag2;
  logic [64:0] sh, step;
  logic [33:0] diff;
  logic        q_neg, r_neg;
  logic [31:0] quo, rem;
  logic        unused_msb;

  // Operand magnitudes taken at acceptance time
  always_comb begin
    mag1 = opdata1_i;
    mag2 = opdata2_i;
    if (signed_div_i && opdata1_i[31]) mag1 = ~opdata1_i + 32'd1;
    if (signed_div_i && opdata2_i[31]) mag2 = ~opdata2_i + 32'd1;
  end

  // One shift/trial-subtract step plus final sign fix-up
  always_comb begin
    sh    = work_q << 1;
    diff  = {1'b0, sh[64:32]} - {2'b00, dvsr_q};
    step  = diff[33] ? sh : ({diff[32:0], sh[31:0]} | 65'd1);
    q_neg = sdiv_q & (sgn1_q ^ sgn2_q);
    r_neg = sdiv_q & sgn1_q;
    quo   = q_neg ? (~step[31:0] + 32'd1) : step[31:0];
    rem   = r_neg ? (~step[63:32] + 32'd1) : step[63:32];
    unused_msb = step[64];
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    sgn1_d  = sgn1_q;
    sgn2_d  = sgn2_q;
    sdiv_d  = sdiv_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          work_d  = {33'd0, mag1};
          dvsr_d  = mag2;
          sgn1_d  = opdata1_i[31];
          sgn2_d  = opdata2_i[31];
          sdiv_d  = signed_div_i;
          cnt_d   = 6'd0;
          state_d = (opdata2_i == 32'd0) ? DIVZERO : BUSY;
        end
      end
      DIVZERO: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          res_d   = 64'd0;
          state_d = DONE;
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            res_d   = {rem, quo};
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (annul_i || !start_i) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      work_q  <= 65'd0;
      dvsr_q  <= 32'd0;
      sgn1_q  <= 1'b0;
      sgn2_q  <= 1'b0;
      sdiv_q  <= 1'b0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      sgn1_q  <= sgn1_d;
      sgn2_q  <= sgn2_d;
      sdiv_q  <= sdiv_d;
      res_q   <= res_d;
    end
  end

  assign ready_o  = (state_q == DONE);
  assign result_o = res_q;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-low. Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-low reset.
- start_i, in, 1: request a divide. Held high by the hazard unit until ready_o is seen.
- annul_i, in, 1: cancel the current divide (flush or exception).
- signed_div_i, in, 1: 1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i, in, 32: dividend.
- opdata2_i, in, 32: divisor.
- result_o, out, 64: {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready_o, out, 1: 1 = result ready, 0 = result not ready.

Function
REQ-002 The FSM SHALL have four states: IDLE, DIVZERO, BUSY, DONE.
REQ-003 In IDLE, start_i=1 and annul_i=0 SHALL latch opdata1_i, opdata2_i and signed_div_i on that edge (call it E0).
- Next state is DIVZERO if opdata2_i==0, else BUSY.
REQ-004 Operand changes after E0 SHALL be ignored until the FSM returns to IDLE.
REQ-005 Operand preparation at E0 for signed mode:
- Operands are converted to magnitude (two's-complement negate if bit31=1).
- The original sign bits are retained for correction.
REQ-006 BUSY SHALL perform one restoring shift-subtract iteration per edge, using a 6-bit counter cleared at E0.
- Iterations occur on edges E1..E32.
- On E32, the FSM enters DONE and result_o is loaded.
REQ-007 Each iteration: shift the 65-bit working register left by 1, then trial-subtract the divisor from the upper 33 bits.
- If no borrow: keep the difference and set quotient LSB=1.
- Otherwise: restore and set LSB=0.
REQ-008 Signed sign correction at load time:
- Quotient is negated if the dividend and divisor signs differ.
- Remainder takes the dividend's sign.
REQ-009 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-010 DIVZERO SHALL load result_o=64'h0 and enter DONE on E1.
REQ-011 ready_o SHALL be 1 exactly while the state is DONE; it is decoded from registered state, with no combinational path from the inputs.
- Normal latency is start sampled at E0 -> ready_o high after E32 (33 edges).
- Divide-by-zero latency is ready_o high after E1.
REQ-012 DONE SHALL hold result_o and ready_o while start_i=1, and go to IDLE on the first edge with start_i=0.
- ready_o then falls.
- result_o holds its value until the next load.
REQ-013 annul_i=1 on any edge in BUSY, DIVZERO or DONE SHALL force IDLE with the counter cleared.
- ready_o falls after that edge.
- result_o is not updated by the annulled operation.
REQ-014 annul_i=1 in IDLE SHALL block acceptance of start_i on that edge.
REQ-015 A new operation SHALL NOT be accepted in the same edge that leaves DONE.
- It is accepted earliest one edge after returning to IDLE.
REQ-016 Simultaneous start_i=1 and annul_i=1 SHALL resolve to annul.

Reset
REQ-017 rst=0 SHALL asynchronously force:
- state=IDLE, counter=0;
- working register, latched operands and result_o = 0;
- ready_o=0.
REQ-018 Deassertion of rst SHALL take effect on the next rising clk edge, with no operation in progress.
REQ-019 Reset asserted mid-BUSY SHALL discard the operation; no stale ready_o may appear afterwards.

Verification
REQ-020 Unsigned 100 / 7, start held high:
- ready_o stays 0 through E32 and is 1 after E32.
- result_o = {32'd2, 32'd14}.
- Dropping start_i returns ready_o to 0 one edge later.
REQ-021 Signed -7 / 2:
- result_o = {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed 7 / -2 gives {0x00000001, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF gives {0x0, 0x80000000}.
REQ-022 Divide by zero (0x1234 / 0): ready_o=1 after E1, result_o=64'h0.
REQ-023 annul_i pulsed at E10 of a 0xFFFFFFFF / 3 unsigned divide:
- ready_o never rises for it and result_o is unchanged.
- A 9 / 3 started at E11 completes with {0, 3} after 33 edges.
REQ-024 rst asserted low mid-BUSY (at E20):
- All outputs read 0 immediately.
- After release, 0xFFFFFFFF / 1 unsigned yields {0, 0xFFFFFFFF}.
REQ-025 Operand stability: opdata1_i and opdata2_i are randomized every cycle during BUSY; the result SHALL still match the values latched at E0.
